error_formula_scanner: RTL and testbench
========================================

ERROR_FORMULA_SCANNER -- requirements
Module: error_formula_scanner

Interface
REQ-001 SHALL have parameter N_X, default 1, count of universal inputs x (legal range 1..16).
REQ-002 SHALL have parameter N_Y, default 2, count of existential outputs y (legal range 1..8).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin scan; sampled only in IDLE or DONE.
REQ-007 stop_first  input  1  sampled with start; 1 = halt at first error.
REQ-008 x_out  output  N_X  current x assignment offered to the external Skolem candidate.
REQ-009 x_valid  output  1  x_out is valid and a candidate y is requested.
REQ-010 y_in  input  N_Y  candidate Skolem output for x_out, with y_in[0] as first existential.
REQ-011 y_valid  input  1  y_in is valid this cycle.
REQ-012 busy  output  1  scan in progress.
REQ-013 done  output  1  scan finished; held until the next accepted start or rst.
REQ-014 err_found  output  1  at least one error found in the current or last scan.
REQ-015 err_count  output  N_X+1  number of x assignments that produced an error.
REQ-016 cex_x  output  N_X  x of the first error.
REQ-017 cex_y  output  N_Y  y_in of the first error.

Function
REQ-018 Formula SHALL be F(x,y) = XOR-reduction of all bits of x and y.
REQ-019 Per x, error SHALL be defined as sat(x) AND NOT F(x,y_in), where sat(x) = exists y with F(x,y)=1.
REQ-020 States SHALL be IDLE, SAT_SCAN, REQ, DONE, encoded as a single FSM.
REQ-021 IDLE/DONE + start=1: next cycle SAT_SCAN, with x=0 and ycnt=0; err_count, err_found, cex_x and cex_y cleared; stop_first latched; done=0.
REQ-022 SAT_SCAN, one y per cycle: if F(x,ycnt)=1, go to REQ; else if ycnt=2^N_Y-1, x is unsat and the FSM advances as in REQ-025 with no error; else ycnt+1.
REQ-023 REQ: x_valid=1 and x_out held stable until a cycle with y_valid=1; there is no timeout.
REQ-024 REQ with y_valid=1: evaluate the error that same cycle; on error, err_count+1 and err_found=1; if err_count was 0, capture cex_x=x and cex_y=y_in.
REQ-025 Advance: if x=2^N_X-1, or the latched stop_first=1 and this x errored, go to DONE; else x+1, ycnt=0, go to SAT_SCAN.
REQ-026 y_valid SHALL be ignored outside REQ.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 busy=1 exactly in SAT_SCAN and REQ; x_valid=1 only in REQ; done=1 only in DONE.
REQ-029 err_count SHALL NOT wrap: its maximum value 2^N_X fits in N_X+1 bits.
REQ-030 x_out SHALL equal the internal x in all states (0 in IDLE).
REQ-031 Latency per sat x SHALL be (ycnt hits + 1) cycles in SAT_SCAN plus REQ wait; minimum 2 cycles per x.

Reset
REQ-032 rst=1 SHALL force IDLE at the next edge, in any state including mid-REQ.
REQ-033 On reset, x_valid=0, busy=0, done=0, err_found=0, err_count=0, cex_x=0, cex_y=0, x_out=0.
REQ-034 After reset release, the block SHALL require a fresh start; no scan resumes.

Verification
REQ-035 Defaults, responder y_in={y[1]=~x, y[0]=0} with y_valid in the same cycle as x_valid, stop_first=0 -> done=1, err_count=0, err_found=0, two REQ handshakes (x=0, x=1).
REQ-036 Defaults, responder y_in=2'b00 -> x=0 errors, x=1 passes; done with err_count=1, cex_x=0, cex_y=00.
REQ-037 Defaults, y_in=2'b11, stop_first=1 -> DONE immediately after x=0; err_count=1, cex_y=11, no x_valid for x=1; same run with stop_first=0 -> err_count=1 and x=1 is also queried.
REQ-038 Responder delays y_valid by 3 cycles -> x_valid stays high 4 cycles and x_out is stable throughout; a y_valid pulse in SAT_SCAN has no effect.
REQ-039 rst asserted during REQ with err_count=1 -> next cycle all outputs at reset values; start pulse while busy is ignored.
REQ-040 N_X=3, N_Y=1, y_in=0 always -> errors exactly on the x values with even parity; err_count=4, cex_x=000.

Source files
------------

// File: rtl/error_formula_scanner_if.sv
// Handshake bundle between the scanner and an external Skolem-function candidate.
interface error_formula_scanner_if #(
    parameter int N_X = 1,
    parameter int N_Y = 2
);
    logic           start;
    logic           stop_first;
    logic [N_X-1:0] x_out;
    logic           x_valid;
    logic [N_Y-1:0] y_in;
    logic           y_valid;
    logic           busy;
    logic           done;
    logic           err_found;
    logic [N_X:0]   err_count;
    logic [N_X-1:0] cex_x;
    logic [N_Y-1:0] cex_y;

    modport master (
        output start, stop_first, y_in, y_valid,
        input  x_out, x_valid, busy, done, err_found, err_count, cex_x, cex_y
    );

    modport slave (
        input  start, stop_first, y_in, y_valid,
        output x_out, x_valid, busy, done, err_found, err_count, cex_x, cex_y
    );
endinterface

// File: rtl/error_formula_scanner.sv
// Purpose: checks a Skolem candidate for F(x,y)=^{x,y} over every x, counting errors and keeping the first counterexample.
// Latency: per x, one cycle per y tried in SAT_SCAN plus the REQ wait; at least 2 cycles per x.
// Backpressure: x_valid holds x_out stable until y_valid arrives, with no timeout; start is ignored while busy.
module error_formula_scanner #(
    parameter int N_X = 1,
    parameter int N_Y = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    error_formula_scanner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SAT_SCAN, REQ, DONE} state_t;

    state_t         state;
    logic [N_X-1:0] x;
    logic [N_Y-1:0] ycnt;
    logic           stop_lat;
    logic           busy_q;
    logic           done_q;
    logic           xv_q;
    logic           found_q;
    logic [N_X:0]   cnt_q;
    logic [N_X-1:0] cex_x_q;
    logic [N_Y-1:0] cex_y_q;

    logic f_scan;
    logic f_cand;
    logic x_last;

    assign f_scan = ^{x, ycnt};
    assign f_cand = ^{x, bus.y_in};
    assign x_last = (x == {N_X{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            x        <= '0;
            ycnt     <= '0;
            stop_lat <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            xv_q     <= 1'b0;
            found_q  <= 1'b0;
            cnt_q    <= '0;
            cex_x_q  <= '0;
            cex_y_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= SAT_SCAN;
                        x        <= '0;
                        ycnt     <= '0;
                        cnt_q    <= '0;
                        found_q  <= 1'b0;
                        cex_x_q  <= '0;
                        cex_y_q  <= '0;
                        stop_lat <= bus.stop_first;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                SAT_SCAN: begin
                    if (f_scan) begin
                        state <= REQ;
                        xv_q  <= 1'b1;
                    end else if (ycnt == {N_Y{1'b1}}) begin
                        // Unsatisfiable x: move on without consulting the candidate.
                        if (x_last) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            x    <= x + 1'b1;
                            ycnt <= '0;
                        end
                    end else begin
                        ycnt <= ycnt + 1'b1;
                    end
                end
                REQ: begin
                    if (bus.y_valid) begin
                        xv_q <= 1'b0;
                        if (!f_cand) begin
                            cnt_q   <= cnt_q + 1'b1;
                            found_q <= 1'b1;
                            if (cnt_q == '0) begin
                                cex_x_q <= x;
                                cex_y_q <= bus.y_in;
                            end
                        end
                        if (x_last || (stop_lat && !f_cand)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state <= SAT_SCAN;
                            x     <= x + 1'b1;
                            ycnt  <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x_out     = x;
    assign bus.x_valid   = xv_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_found = found_q;
    assign bus.err_count = cnt_q;
    assign bus.cex_x     = cex_x_q;
    assign bus.cex_y     = cex_y_q;
endmodule

// File: tb/tb_error_formula_scanner.sv
// Directed bench: default-parameter scanner driven by several candidate responders, plus a N_X=3/N_Y=1 instance.
module tb_error_formula_scanner;
    logic clk;
    logic rst;

    error_formula_scanner_if #(.N_X(1), .N_Y(2)) bus0 ();
    error_formula_scanner_if #(.N_X(3), .N_Y(1)) bus1 ();

    error_formula_scanner #(.N_X(1), .N_Y(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    error_formula_scanner #(.N_X(3), .N_Y(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks;
    int n_fail;

    int         hs;
    int         xvm;
    logic       st;
    logic [1:0] qm;
    int         hs1;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: y={~x,0} (always correct); 1: y=00; 2: y=11; 3: correct y delayed 3 cycles plus a stray y_valid in SAT_SCAN
    task automatic run0(input int mode, input logic sf, output int hs_o, output int xv_max,
                        output logic stable, output logic [1:0] qmask);
        int   run;
        logic held;
        logic pulsed;
        hs_o = 0; xv_max = 0; stable = 1'b1; qmask = 2'b00; run = 0; held = 1'b0; pulsed = 1'b0;
        bus0.stop_first = sf;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus0.done) break;
            if (bus0.x_valid) begin
                if (run == 0) held = bus0.x_out[0];
                else if (bus0.x_out[0] !== held) stable = 1'b0;
                run++;
                case (mode)
                    1:       bus0.y_in = 2'b00;
                    2:       bus0.y_in = 2'b11;
                    default: bus0.y_in = {~bus0.x_out[0], 1'b0};
                endcase
                if (mode != 3 || run >= 4) begin
                    bus0.y_valid = 1'b1;
                    hs_o++;
                    if (run > xv_max) xv_max = run;
                    qmask[bus0.x_out[0]] = 1'b1;
                    run = 0;
                end else begin
                    bus0.y_valid = 1'b0;
                end
            end else begin
                bus0.y_in    = 2'b00;
                bus0.y_valid = (mode == 3) && bus0.busy && !pulsed;
                if (bus0.y_valid) pulsed = 1'b1;
            end
            @(negedge clk);
        end
        bus0.y_valid = 1'b0;
        check_eq("scan_done", {31'd0, bus0.done}, 32'd1);
        check_eq("busy_at_done", {31'd0, bus0.busy}, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        clk = 1'b0; rst = 1'b1;
        bus0.start = 0; bus0.stop_first = 0; bus0.y_in = '0; bus0.y_valid = 0;
        bus1.start = 0; bus1.stop_first = 0; bus1.y_in = '0; bus1.y_valid = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, bus0.busy}, 0);
        check_eq("rst_done", {31'd0, bus0.done}, 0);
        check_eq("rst_xvalid", {31'd0, bus0.x_valid}, 0);
        check_eq("rst_errcnt", {30'd0, bus0.err_count}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", {31'd0, bus0.busy}, 0);

        // All-correct candidate
        run0(0, 1'b0, hs, xvm, st, qm);
        check_eq("good_errcnt", {30'd0, bus0.err_count}, 0);
        check_eq("good_found", {31'd0, bus0.err_found}, 0);
        check_eq("good_hs", hs, 2);
        check_eq("good_xvlen", xvm, 1);

        // y=00: x=0 errors, x=1 passes
        run0(1, 1'b0, hs, xvm, st, qm);
        check_eq("y00_errcnt", {30'd0, bus0.err_count}, 1);
        check_eq("y00_found", {31'd0, bus0.err_found}, 1);
        check_eq("y00_cex_x", {31'd0, bus0.cex_x}, 0);
        check_eq("y00_cex_y", {30'd0, bus0.cex_y}, 0);

        // y=11 with stop_first: halts after x=0
        run0(2, 1'b1, hs, xvm, st, qm);
        check_eq("y11s_errcnt", {30'd0, bus0.err_count}, 1);
        check_eq("y11s_cex_y", {30'd0, bus0.cex_y}, 3);
        check_eq("y11s_hs", hs, 1);
        check_eq("y11s_qmask", {30'd0, qm}, 1);

        // y=11 without stop_first: x=1 also queried
        run0(2, 1'b0, hs, xvm, st, qm);
        check_eq("y11_errcnt", {30'd0, bus0.err_count}, 1);
        check_eq("y11_qmask", {30'd0, qm}, 3);

        // Delayed responder with stray y_valid in SAT_SCAN
        run0(3, 1'b0, hs, xvm, st, qm);
        check_eq("dly_xvlen", xvm, 4);
        check_eq("dly_stable", {31'd0, st}, 1);
        check_eq("dly_errcnt", {30'd0, bus0.err_count}, 0);
        check_eq("dly_hs", hs, 2);

        // Reset in the middle of REQ, after one error
        bus0.stop_first = 1'b0;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus0.x_valid && bus0.x_out[0] == 1'b1) break;
            bus0.y_in    = 2'b00;
            bus0.y_valid = bus0.x_valid;
            @(negedge clk);
        end
        bus0.y_valid = 1'b0;
        check_eq("mid_xvalid", {31'd0, bus0.x_valid}, 1);
        check_eq("mid_errcnt", {30'd0, bus0.err_count}, 1);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        check_eq("busy_start_xvalid", {31'd0, bus0.x_valid}, 1);
        check_eq("busy_start_errcnt", {30'd0, bus0.err_count}, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_xvalid", {31'd0, bus0.x_valid}, 0);
        check_eq("mrst_busy", {31'd0, bus0.busy}, 0);
        check_eq("mrst_done", {31'd0, bus0.done}, 0);
        check_eq("mrst_found", {31'd0, bus0.err_found}, 0);
        check_eq("mrst_errcnt", {30'd0, bus0.err_count}, 0);
        check_eq("mrst_cex_x", {31'd0, bus0.cex_x}, 0);
        check_eq("mrst_cex_y", {30'd0, bus0.cex_y}, 0);
        check_eq("mrst_xout", {31'd0, bus0.x_out}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("norsm_busy", {31'd0, bus0.busy}, 0);
        check_eq("norsm_xvalid", {31'd0, bus0.x_valid}, 0);

        // N_X=3, N_Y=1, y=0: errors on even-parity x
        hs1 = 0;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus1.done) break;
            bus1.y_in    = 1'b0;
            bus1.y_valid = bus1.x_valid;
            if (bus1.x_valid) hs1++;
            @(negedge clk);
        end
        bus1.y_valid = 1'b0;
        check_eq("p3_done", {31'd0, bus1.done}, 1);
        check_eq("p3_errcnt", {28'd0, bus1.err_count}, 4);
        check_eq("p3_cex_x", {29'd0, bus1.cex_x}, 0);
        check_eq("p3_found", {31'd0, bus1.err_found}, 1);
        check_eq("p3_hs", hs1, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
